cnt163_chain: RTL and testbench
===============================

# cnt163_chain

Synchronous, cascadable binary counter built from 4-bit 163-style slices: synchronous clear, parallel load, dual count enables (ENP/ENT) and ripple-carry output. It is the register stage that consumes the 4-bit next-state/carry logic of one counter slice and feeds its state back into that logic each cycle. Chained slices use single-cycle carry lookahead, so the whole counter advances in one clock, like a discrete 74163 cascade.

## Interface
- `NSLICE`, default 2: number of 4-bit slices; counter width `W = 4*NSLICE`. Legal range is 1 to 8.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset. Synchronous, active-low. Forces all state to zero.
- `clr_n` input 1: functional synchronous clear, active-low.
- `load_n` input 1: synchronous parallel load, active-low.
- `enp` input 1: count enable P. Does not gate `rco`.
- `ent` input 1: count enable T. Gates `rco`.
- `d` input W: parallel load data.
- `q` output W: counter state, registered.
- `rco` output 1: ripple carry out. Combinational: `ent & (q == all ones)`.
- `slice_tc` output NSLICE: per-slice terminal count. Bit i is `ent & (all slices 0..i are 4'hF)`. Combinational.
- `wrap` output 1: registered. One-cycle pulse, high in the cycle after the counter advances from all ones to zero.

## Operation
Next-state priority is evaluated on each rising `clk` edge:
1. `!rst_n`: `q <= 0`, `wrap <= 0`.
2. `!clr_n`: `q <= 0`, `wrap <= 0`.
3. `!load_n`: `q <= d`, `wrap <= 0`. Load ignores `enp` and `ent`.
4. `enp & ent`: `q <= q + 1` modulo 2^W. `wrap <= (q == all ones)`.
5. Otherwise: hold `q`, `wrap <= 0`.

Slice behaviour:
- Slice i increments when `enp & ent & slice_tc[i-1]`. Slice 0 uses `enp & ent` as its enable.
- The carry is lookahead, not registered, so there is no multi-cycle ripple.

Arithmetic:
- Unsigned. Wrap from `2^W - 1` to `0` is silent apart from the `wrap` pulse.

Enable and carry rules:
- `rco` tracks `ent` combinationally even when `enp = 0`. This lets an external cascade chain `rco` into the next device's `ent`.
- `clr_n` and `load_n` asserted together: clear wins.
- `rst_n` low mid-count: `q = 0` at the next edge regardless of any other input.

## Timing
- Reset values: `q = 0`, `wrap = 0`, `rco = 0`, `slice_tc = 0`. The combinational outputs are zero because `q = 0` and, for NSLICE ≥ 1, no slice is at terminal count.
- Latency from clear, load or count to a change on `q`: 1 cycle.
- `rco` and `slice_tc` settle in the same cycle as `q` and `ent`.
- `wrap` is high for exactly the cycle after the wrapping edge.
- Inputs are sampled only at rising `clk`. There are no asynchronous paths.
- The critical path is the lookahead AND chain across NSLICE slices. It must close at the codebase's standard clock target for NSLICE = 8.

## Structure
- Shared package `cnt163_pkg`:
  - `SLICE_W = 4`
  - `localparam` function `cnt_w(nslice)`
  - enum `cnt_op_e` with values `OP_CLR`, `OP_LOAD`, `OP_CNT`, `OP_HOLD`. This is the decoded priority result and is shared with the verification model.
- Sub-module `cnt163_slice`: 4-bit register plus its next-state logic.
  - Inputs: `op`, `d4`, `cin` (slice enable).
  - Outputs: `q4`, `tc4`.
- `cnt163_chain`:
  - instantiates NSLICE slices
  - decodes `op` once
  - builds the lookahead carry chain
  - owns the `wrap` register

## Test plan
All scenarios use NSLICE = 2, W = 8.
- Reset and clear:
  - Hold `rst_n = 0` for 2 cycles → `q = 8'h00`, `rco = 0`, `wrap = 0`.
  - Preload `8'h5A`, then `clr_n = 0` with `load_n = 0`, `d = 8'h33` → `q = 8'h00` (clear beats load).
- Load priority: `load_n = 0`, `d = 8'hA7`, `enp = ent = 1` → `q = 8'hA7` next cycle, not `8'hA8`.
- Slice carry:
  - Load `8'h0F`, then count → `q = 8'h10` in one cycle.
  - While at `8'h0F` with `ent = 1`: `slice_tc = 2'b01`, `rco = 0`.
- Wrap:
  - Load `8'hFE`, count 2 cycles → `q` goes `8'hFF` then `8'h00`.
  - `rco = 1` only while `q = 8'hFF` and `ent = 1`.
  - `wrap = 1` in the cycle `q = 8'h00`, then 0.
- Enable gating at `q = 8'hFF`:
  - `enp = 0`, `ent = 1` → `q` holds, `rco = 1`.
  - `enp = 1`, `ent = 0` → `q` holds, `rco = 0`.
- Reset mid-count: free-run from `8'h00`, drop `rst_n` at `q = 8'h37` → `q = 8'h00` next edge, count resumes from 0 after release.

Source files
------------

// File: rtl/cnt163_pkg.sv
// Shared types and sizing helpers for the 163-style cascadable counter.
// The decoded operation enum is also used by verification models.
package cnt163_pkg;

  localparam int SLICE_W = 4;

  function automatic int cnt_w(input int nslice);
    return nslice * SLICE_W;
  endfunction

  // Priority-decoded operation for one clock edge, highest first.
  typedef enum logic [1:0] {
    OP_CLR,
    OP_LOAD,
    OP_CNT,
    OP_HOLD
  } cnt_op_e;

endpackage

// File: rtl/cnt163_if.sv
// Control/data bundle of the counter chain; the counter is the slave side.
interface cnt163_if
  import cnt163_pkg::*;
#(
  parameter int NSLICE = 2
) ();

  localparam int W = cnt_w(NSLICE);

  logic              clr_n;
  logic              load_n;
  logic              enp;
  logic              ent;
  logic [W-1:0]      d;
  logic [W-1:0]      q;
  logic              rco;
  logic [NSLICE-1:0] slice_tc;
  logic              wrap;

  modport master (
    output clr_n, load_n, enp, ent, d,
    input  q, rco, slice_tc, wrap
  );

  modport slave (
    input  clr_n, load_n, enp, ent, d,
    output q, rco, slice_tc, wrap
  );

endinterface

// File: rtl/cnt163_slice.sv
// One 4-bit counter slice: state register plus its next-state logic.
// tc4 reports the slice at all ones; ent gating is applied by the chain.
module cnt163_slice
  import cnt163_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  cnt_op_e            op,
  input  logic [SLICE_W-1:0] d4,
  input  logic               cin,
  output logic [SLICE_W-1:0] q4,
  output logic               tc4
);

  // NOTE: state registers use non-blocking assignments so every slice samples
  // the same pre-edge values; blocking here would make the cascade order-dependent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q4 <= '0;
    end else begin
      unique case (op)
        OP_CLR:  q4 <= '0;
        OP_LOAD: q4 <= d4;
        OP_CNT:  if (cin) q4 <= q4 + SLICE_W'(1);
        OP_HOLD: q4 <= q4;
        default: q4 <= q4;
      endcase
    end
  end

  assign tc4 = &q4;

endmodule

// File: rtl/cnt163_chain.sv
// Cascade of NSLICE 163-style slices with single-cycle carry lookahead,
// so the whole W-bit counter advances in one clock.
module cnt163_chain
  import cnt163_pkg::*;
#(
  parameter int NSLICE = 2
) (
  input logic     clk,
  input logic     rst_n,
  cnt163_if.slave bus
);

  localparam int W = cnt_w(NSLICE);

  cnt_op_e           op;
  logic [NSLICE-1:0] tc4;
  logic [NSLICE-1:0] cin;
  logic [NSLICE-1:0] tc_chain;
  logic [W-1:0]      q_int;
  logic              wrap_q;

  // NOTE: assigning a default before the if-chain keeps this purely
  // combinational; a path that leaves op unassigned would infer a latch.
  always_comb begin
    op = OP_HOLD;
    if (!bus.clr_n)                op = OP_CLR;
    else if (!bus.load_n)          op = OP_LOAD;
    else if (bus.enp && bus.ent)   op = OP_CNT;
  end

  // Lookahead: slice i's terminal count is ent AND every slice 0..i at all ones.
  always_comb begin
    logic acc;
    tc_chain = '0;
    acc      = bus.ent;
    for (int i = 0; i < NSLICE; i++) begin
      acc         = acc & tc4[i];
      tc_chain[i] = acc;
    end
  end

  for (genvar i = 0; i < NSLICE; i++) begin : g_slice
    // enp & ent are already folded into OP_CNT, so slice 0 always has carry-in.
    if (i == 0) begin : g_lsb
      assign cin[i] = 1'b1;
    end else begin : g_upper
      assign cin[i] = tc_chain[i-1];
    end

    cnt163_slice u_slice (
      .clk   (clk),
      .rst_n (rst_n),
      .op    (op),
      .d4    (bus.d[i*SLICE_W +: SLICE_W]),
      .cin   (cin[i]),
      .q4    (q_int[i*SLICE_W +: SLICE_W]),
      .tc4   (tc4[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wrap_q <= 1'b0;
    else        wrap_q <= (op == OP_CNT) && (&q_int);
  end

  assign bus.q        = q_int;
  assign bus.slice_tc = tc_chain;
  assign bus.rco      = tc_chain[NSLICE-1];
  assign bus.wrap     = wrap_q;

endmodule

// File: tb/tb_cnt163_chain.sv
// Directed-vector bench for cnt163_chain (NSLICE = 2): stimulus queues
// expected results, a separate monitor compares them after each clock edge.
module tb_cnt163_chain;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  cnt163_if #(.NSLICE(2)) bus ();

  cnt163_chain #(.NSLICE(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    string      name;
    int         cyc;
    logic [7:0] q;
    logic       rco;
    logic [1:0] tc;
    logic       wrap;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: the counter presents a new state every edge; compare one cycle in.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        e = sb.pop_front();
        checks++;
        errors++;
        $display("FAIL %s not sampled got none want cycle %0d", e.name, e.cyc);
      end
      if (sb.size() > 0 && sb[0].cyc == cyc) begin
        e = sb.pop_front();
        check({e.name, ".q"},        32'(bus.q),        32'(e.q));
        check({e.name, ".rco"},      32'(bus.rco),      32'(e.rco));
        check({e.name, ".slice_tc"}, 32'(bus.slice_tc), 32'(e.tc));
        check({e.name, ".wrap"},     32'(bus.wrap),     32'(e.wrap));
      end
    end
  end

  // Drive one cycle of inputs at the falling edge; optionally queue the
  // state expected right after the following rising edge.
  task automatic step(input logic rstn, input logic clrn, input logic loadn,
                      input logic penp, input logic pent, input logic [7:0] pd,
                      input bit chk, input string name, input logic [7:0] eq,
                      input logic erco, input logic [1:0] etc, input logic ewrap);
    exp_t e;
    @(negedge clk);
    rst_n      = rstn;
    bus.clr_n  = clrn;
    bus.load_n = loadn;
    bus.enp    = penp;
    bus.ent    = pent;
    bus.d      = pd;
    if (chk) begin
      e.name = name;
      e.cyc  = cyc + 1;
      e.q    = eq;
      e.rco  = erco;
      e.tc   = etc;
      e.wrap = ewrap;
      sb.push_back(e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v;
    int         n;
    rst_n      = 1'b0;
    bus.clr_n  = 1'b1;
    bus.load_n = 1'b1;
    bus.enp    = 1'b0;
    bus.ent    = 1'b0;
    bus.d      = 8'h00;

    //   rst clr ld enp ent d      chk name              q      rco tc     wrap
    step(0, 1, 1, 0, 0, 8'h00, 1, "rst1",            8'h00, 0, 2'b00, 0);
    step(0, 1, 1, 0, 0, 8'h00, 1, "rst2",            8'h00, 0, 2'b00, 0);
    step(1, 1, 0, 0, 0, 8'h5A, 1, "preload5a",       8'h5A, 0, 2'b00, 0);
    step(1, 0, 0, 1, 1, 8'h33, 1, "clr_beats_load",  8'h00, 0, 2'b00, 0);
    step(1, 1, 0, 1, 1, 8'hA7, 1, "load_prio",       8'hA7, 0, 2'b00, 0);
    step(1, 1, 0, 1, 1, 8'h0F, 1, "tc_at_0f",        8'h0F, 0, 2'b01, 0);
    step(1, 1, 1, 1, 1, 8'h00, 1, "slice_carry",     8'h10, 0, 2'b00, 0);
    step(1, 1, 0, 0, 1, 8'hFE, 1, "load_fe",         8'hFE, 0, 2'b00, 0);
    step(1, 1, 1, 1, 1, 8'h00, 1, "count_ff",        8'hFF, 1, 2'b11, 0);
    step(1, 1, 1, 1, 1, 8'h00, 1, "wrap_pulse",      8'h00, 0, 2'b00, 1);
    step(1, 1, 1, 0, 0, 8'h00, 1, "wrap_drop",       8'h00, 0, 2'b00, 0);
    step(1, 1, 0, 0, 0, 8'hFF, 1, "load_ff",         8'hFF, 0, 2'b00, 0);
    step(1, 1, 1, 0, 1, 8'h00, 1, "hold_enp0",       8'hFF, 1, 2'b11, 0);
    step(1, 1, 1, 1, 0, 8'h00, 1, "hold_ent0",       8'hFF, 0, 2'b00, 0);
    step(1, 0, 1, 0, 0, 8'h00, 1, "clear",           8'h00, 0, 2'b00, 0);

    // Free-run from zero up to 8'h37; low slice is at F on 0F, 1F, 2F.
    v = 8'h00;
    for (int i = 0; i < 8'h37; i++) begin
      v = v + 8'h01;
      step(1, 1, 1, 1, 1, 8'h00, 1, "free_run", v, 0,
           (v[3:0] == 4'hF) ? 2'b01 : 2'b00, 0);
    end

    step(0, 0, 0, 1, 1, 8'hAA, 1, "rst_mid",         8'h00, 0, 2'b00, 0);
    step(1, 1, 1, 1, 1, 8'h00, 1, "resume1",         8'h01, 0, 2'b00, 0);
    step(1, 1, 1, 1, 1, 8'h00, 1, "resume2",         8'h02, 0, 2'b00, 0);
    step(1, 1, 1, 0, 0, 8'h00, 0, "",                8'h00, 0, 2'b00, 0);

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    while (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL %s not sampled got none want cycle %0d", e.name, e.cyc);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
